// File: rtl/netlist_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : netlist_sched_pkg
// Description : Shared FSM state encoding and default sizing for the
//               netlist evaluation scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package netlist_sched_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SETTLE_WAIT = 2'd1,
        CAPTURE     = 2'd2,
        RESP        = 2'd3
    } sched_state_e;

    localparam int c_default_vec_w  = 45;
    localparam int c_default_settle = 2;
    localparam int c_eval_cnt_w     = 16;

endpackage
`default_nettype wire

// File: rtl/netlist_eval_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; search begins one past
//               the previous winner and wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import netlist_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last_grant,
    output logic [NREQ-1:0]         grant
);

    localparam int c_idx_w = $clog2(NREQ);

    logic [c_idx_w:0]   w_sum;
    logic [c_idx_w-1:0] w_idx;
    logic               w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, last_grant} + (c_idx_w + 1)'(k);
            if (w_sum >= (c_idx_w + 1)'(NREQ)) begin
                w_sum = w_sum - (c_idx_w + 1)'(NREQ);
            end
            w_idx = w_sum[c_idx_w-1:0];
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/netlist_eval_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : netlist_eval_scheduler
// Description : Time-shares one external combinational netlist among NREQ
//               requesters, sampling its output a fixed settle time later.
// Revision    : 1.0 - initial release
// ============================================================================
module netlist_eval_scheduler
    import netlist_sched_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int VEC_W  = c_default_vec_w,
    parameter int SETTLE = c_default_settle
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*VEC_W-1:0]   req_vec,
    output logic [NREQ-1:0]         req_ready,
    output logic [VEC_W-1:0]        dut_in,
    input  logic                    dut_out,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic                    resp_bit,
    output logic [c_eval_cnt_w-1:0] eval_count,
    output logic                    busy
);

    localparam int c_id_w  = $clog2(NREQ);
    localparam int c_cnt_w = 4;

    sched_state_e            r_state;
    sched_state_e            w_state_nxt;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_id_w-1:0]       r_last_grant;
    logic [VEC_W-1:0]        r_dut_in;
    logic [c_id_w-1:0]       r_resp_id;
    logic                    r_resp_bit;
    logic [c_eval_cnt_w-1:0] r_eval_count;

    logic [NREQ-1:0]         w_grant;
    logic [c_id_w-1:0]       w_grant_idx;
    logic [VEC_W-1:0]        w_sel_vec;
    logic                    w_take;
    logic                    w_sample;
    logic                    w_accept;

    rr_arbiter #(
        .NREQ       (NREQ)
    ) u_arbiter (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    always_comb begin
        w_grant_idx = '0;
        w_sel_vec   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx = c_id_w'(i);
                w_sel_vec   = req_vec[i*VEC_W +: VEC_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_sample    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_take      = 1'b1;
                    w_state_nxt = SETTLE_WAIT;
                end
            end
            SETTLE_WAIT: begin
                if (r_cnt == '0) begin
                    w_sample    = 1'b1;
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // dut_out is latched on the edge that enters CAPTURE, which is exactly
    // SETTLE edges after dut_in changed; CAPTURE then presents it in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_last_grant <= c_id_w'(NREQ - 1);
            r_dut_in     <= '0;
            r_resp_id    <= '0;
            r_resp_bit   <= 1'b0;
            r_eval_count <= '0;
        end else begin
            if (w_take) begin
                r_cnt        <= c_cnt_w'(SETTLE - 1);
                r_last_grant <= w_grant_idx;
                r_dut_in     <= w_sel_vec;
                r_resp_id    <= w_grant_idx;
            end else if (r_state == SETTLE_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
            if (w_sample) begin
                r_resp_bit <= dut_out;
            end
            if (w_accept && r_eval_count != '1) begin
                r_eval_count <= r_eval_count + c_eval_cnt_w'(1);
            end
        end
    end

    // Gated by rst so no acceptance is advertised while reset is held.
    assign req_ready  = (r_state == IDLE && !rst) ? w_grant : '0;
    assign dut_in     = r_dut_in;
    assign resp_valid = (r_state == RESP);
    assign resp_id    = r_resp_id;
    assign resp_bit   = r_resp_bit;
    assign eval_count = r_eval_count;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_netlist_eval_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_netlist_eval_scheduler
// Description : Self-checking bench with a transaction-level reference model
//               and time-aware netlist models for the sample point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_netlist_eval_scheduler;

    localparam int NREQ = 4;
    localparam int VW   = 45;
    localparam int S    = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*VW-1:0]   req_vec;
    logic [NREQ-1:0]      req_ready;
    logic [VW-1:0]        dut_in;
    logic                 dut_out;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [1:0]           resp_id;
    logic                 resp_bit;
    logic [15:0]          eval_count;
    logic                 busy;

    logic [1:0]  sm_valid  [2];
    logic [15:0] sm_vec    [2];
    logic [1:0]  sm_ready  [2];
    logic [7:0]  sm_in     [2];
    logic        sm_out    [2];
    logic        sm_rvalid [2];
    logic        sm_rready [2];
    logic        sm_id     [2];
    logic        sm_bit    [2];
    logic [15:0] sm_cnt    [2];
    logic        sm_busy   [2];

    always #5 clk = ~clk;

    netlist_eval_scheduler #(.NREQ(NREQ), .VEC_W(VW), .SETTLE(S)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_vec(req_vec),
        .req_ready(req_ready), .dut_in(dut_in), .dut_out(dut_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_bit(resp_bit), .eval_count(eval_count), .busy(busy)
    );

    netlist_eval_scheduler #(.NREQ(2), .VEC_W(8), .SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .req_valid(sm_valid[0]), .req_vec(sm_vec[0]),
        .req_ready(sm_ready[0]), .dut_in(sm_in[0]), .dut_out(sm_out[0]),
        .resp_valid(sm_rvalid[0]), .resp_ready(sm_rready[0]), .resp_id(sm_id[0]),
        .resp_bit(sm_bit[0]), .eval_count(sm_cnt[0]), .busy(sm_busy[0])
    );

    netlist_eval_scheduler #(.NREQ(2), .VEC_W(8), .SETTLE(15)) u_s15 (
        .clk(clk), .rst(rst), .req_valid(sm_valid[1]), .req_vec(sm_vec[1]),
        .req_ready(sm_ready[1]), .dut_in(sm_in[1]), .dut_out(sm_out[1]),
        .resp_valid(sm_rvalid[1]), .resp_ready(sm_rready[1]), .resp_id(sm_id[1]),
        .resp_bit(sm_bit[1]), .eval_count(sm_cnt[1]), .busy(sm_busy[1])
    );

    // Netlist models: output is the input parity only on the cycle that lies
    // exactly SETTLE edges after dut_in changed, inverted parity otherwise.
    logic [VW-1:0] nl_prev = '0;
    int            nl_age  = 0;
    logic [7:0]    sm_prev [2] = '{8'h00, 8'h00};
    int            sm_age  [2] = '{0, 0};

    always @(negedge clk) begin
        if (dut_in != nl_prev) nl_age <= 1;
        else if (nl_age < 1000) nl_age <= nl_age + 1;
        nl_prev <= dut_in;
        for (int k = 0; k < 2; k++) begin
            if (sm_in[k] != sm_prev[k]) sm_age[k] <= 1;
            else if (sm_age[k] < 1000) sm_age[k] <= sm_age[k] + 1;
            sm_prev[k] <= sm_in[k];
        end
    end

    assign dut_out   = (nl_age == S)     ? ^dut_in   : ~^dut_in;
    assign sm_out[0] = (sm_age[0] == 1)  ? ^sm_in[0] : ~^sm_in[0];
    assign sm_out[1] = (sm_age[1] == 15) ? ^sm_in[1] : ~^sm_in[1];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model state (transaction level)
    int              cyc     = 0;
    bit              m_busy  = 1'b0;
    int              m_due   = 0;
    int              m_id    = 0;
    bit              m_bit   = 1'b0;
    int              m_last  = NREQ - 1;
    int unsigned     m_count = 0;
    logic [NREQ-1:0] obs_ready;
    int              grants [$];
    int              gcyc   [$];
    int              seq    = 0;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [VW-1:0] vec_of(input int i);
        return req_vec[i*VW +: VW];
    endfunction

    task automatic new_vec(input int i);
        logic [63:0] t;
        seq++;
        t = {$urandom(), $urandom()};
        t[11:0] = seq[11:0];
        req_vec[i*VW +: VW] = t[VW-1:0];
    endtask

    // One clock cycle: check mid-cycle against the model, return at posedge+1.
    task automatic step();
        int g;
        @(negedge clk);
        cyc++;
        obs_ready = req_ready;
        check("eval_count", eval_count, m_count);
        check("busy", busy, m_busy);
        if (!m_busy) begin
            g = rr_pick(req_valid, m_last);
            check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
            check("resp_valid_idle", resp_valid, 0);
            if (g >= 0) begin
                m_busy = 1'b1;
                m_due  = cyc + S + 2;
                m_id   = g;
                m_bit  = ^vec_of(g);
                m_last = g;
                grants.push_back(g);
                gcyc.push_back(cyc);
            end
        end else begin
            check("req_ready_busy", req_ready, 0);
            if (cyc < m_due) begin
                check("resp_valid_early", resp_valid, 0);
            end else begin
                check("resp_valid", resp_valid, 1);
                check("resp_id", resp_id, m_id);
                check("resp_bit", resp_bit, m_bit);
                if (resp_ready) begin
                    m_busy = 1'b0;
                    if (m_count < 16'hFFFF) m_count++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_dut_in", dut_in, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_bit", resp_bit, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_eval_count", eval_count, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_busy  = 1'b0;
        m_last  = NREQ - 1;
        m_count = 0;
    endtask

    task automatic run_small(input int k);
        int         g_cyc;
        int         r_cyc;
        int         s_val;
        logic [7:0] v;
        s_val = (k == 0) ? 1 : 15;
        v = 8'($urandom_range(1, 255));
        sm_vec[k]    = {v, 8'h00};
        sm_valid[k]  = 2'b10;
        sm_rready[k] = 1'b1;
        g_cyc = -1;
        r_cyc = -1;
        for (int t = 0; t < 40 && r_cyc < 0; t++) begin
            @(negedge clk);
            if (sm_ready[k][1] && g_cyc < 0) g_cyc = t;
            if (sm_rvalid[k] && r_cyc < 0) begin
                r_cyc = t;
                check("small_resp_id", sm_id[k], 1);
                check("small_resp_bit", sm_bit[k], ^v);
            end
            @(posedge clk);
            #1;
            if (g_cyc >= 0) sm_valid[k] = 2'b00;
        end
        check((k == 0) ? "settle1_latency" : "settle15_latency", r_cyc - g_cyc, s_val + 2);
    endtask

    initial begin
        req_valid  = '0;
        req_vec    = '0;
        resp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sm_valid[k]  = '0;
            sm_vec[k]    = '0;
            sm_rready[k] = 1'b1;
        end
        @(posedge clk);
        #1;
        do_reset();

        // Single request, vector 1 -> parity 1
        req_vec[0 +: VW] = 45'h1;
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            if (obs_ready[0]) req_valid[0] = 1'b0;
        end
        check("single_eval_count", eval_count, 1);
        check("single_grants", grants.size(), 1);

        // All requesters held valid: order and spacing
        do_reset();
        grants.delete();
        gcyc.delete();
        for (int i = 0; i < NREQ; i++) new_vec(i);
        req_valid = '1;
        for (int n = 0; n < 22; n++) begin
            step();
            for (int i = 0; i < NREQ; i++) if (obs_ready[i]) new_vec(i);
        end
        check("rr_grant_count", grants.size(), 5);
        for (int k = 0; k < 5 && k < grants.size(); k++) begin
            check("rr_order", grants[k], k % NREQ);
            if (k > 0) check("rr_spacing", gcyc[k] - gcyc[k-1], S + 3);
        end

        // Backpressure with other requesters waiting
        do_reset();
        req_valid  = 4'b0001;
        new_vec(0);
        resp_ready = 1'b0;
        for (int n = 0; n < 16; n++) begin
            step();
            if (obs_ready[0]) begin
                for (int i = 1; i < NREQ; i++) new_vec(i);
                req_valid = 4'b1110;
            end
        end
        resp_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            for (int i = 0; i < NREQ; i++) if (obs_ready[i]) req_valid[i] = 1'b0;
        end

        // Reset during SETTLE_WAIT abandons the evaluation
        do_reset();
        req_valid = 4'b0100;
        new_vec(2);
        step();
        req_valid = '0;
        step();
        check("pre_abort_busy", busy, 1);
        do_reset();
        req_valid = 4'b1100;
        new_vec(3);
        for (int n = 0; n < 8; n++) begin
            step();
            for (int i = 0; i < NREQ; i++) if (obs_ready[i]) req_valid[i] = 1'b0;
        end

        // Saturation of eval_count
        do_reset();
        force dut.r_eval_count = 16'hFFFE;
        #1;
        release dut.r_eval_count;
        m_count   = 16'hFFFE;
        req_valid = 4'b0001;
        new_vec(0);
        for (int n = 0; n < 20; n++) begin
            step();
            if (obs_ready[0]) new_vec(0);
        end
        check("sat_eval_count", eval_count, 16'hFFFF);

        // Randomised traffic
        do_reset();
        req_valid = '0;
        for (int n = 0; n < 500; n++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (obs_ready[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    if (req_valid[i]) new_vec(i);
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    new_vec(i);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 9) < 7);
        end

        // Sample point with SETTLE = 1 and SETTLE = 15
        req_valid = '0;
        do_reset();
        run_small(0);
        run_small(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
